// File: rtl/target_lut_ram_if.sv
// rtl/target_lut_ram_if.sv - lookup/write/invalidate port bundle for target_lut_ram
interface target_lut_ram_if #(
    parameter int ADDR_W   = 3,
    parameter int TARGET_W = 10
);
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [TARGET_W-1:0] wr_data;
    logic                inval_all;
    logic                busy;
    logic                rd_valid;
    logic                rd_hit;
    logic [TARGET_W-1:0] target;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, inval_all,
        input  busy, rd_valid, rd_hit, target
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, inval_all,
        output busy, rd_valid, rd_hit, target
    );
endinterface

// File: rtl/target_lut_ram.sv
// rtl/target_lut_ram.sv - branch-target table with valid bits and sweep invalidation
module target_lut_ram #(
    parameter int ADDR_W      = 3,
    parameter int TARGET_W    = 10,
    parameter int MISS_TARGET = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    target_lut_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]   LAST_PTR = '1;
    localparam logic [TARGET_W-1:0] MISS_VAL = TARGET_W'(MISS_TARGET);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DEPTH-1:0]    r_valid;
    logic [TARGET_W-1:0] r_data [DEPTH];
    logic                r_rd_valid;
    logic                r_rd_hit;
    logic [TARGET_W-1:0] r_target;

    logic w_ready;
    logic w_write;
    logic w_bypass;

    assign w_ready  = (r_state == ST_READY);
    assign w_write  = w_ready && bus.wr_en && !bus.inval_all;
    // Same-cycle write to the looked-up index forwards the new value.
    assign w_bypass = w_write && (bus.rd_addr == bus.wr_addr);

    // Data words carry no reset; validity alone decides hits.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_data[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_CLEAR;
            r_ptr      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_target   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_valid[r_ptr] <= 1'b0;
                    r_ptr          <= r_ptr + 1'b1;
                    r_rd_valid     <= 1'b0;
                    if (r_ptr == LAST_PTR) begin
                        r_state <= ST_READY;
                    end
                end
                ST_READY: begin
                    r_rd_valid <= bus.rd_en;
                    if (bus.rd_en) begin
                        if (w_bypass) begin
                            r_rd_hit <= 1'b1;
                            r_target <= bus.wr_data;
                        end else begin
                            r_rd_hit <= r_valid[bus.rd_addr];
                            r_target <= r_valid[bus.rd_addr] ? r_data[bus.rd_addr] : MISS_VAL;
                        end
                    end
                    if (bus.inval_all) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                    end else if (bus.wr_en) begin
                        r_valid[bus.wr_addr] <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == ST_CLEAR);
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_hit   = r_rd_hit;
    assign bus.target   = r_target;
endmodule

// File: tb/tb_target_lut_ram.sv
// tb/tb_target_lut_ram.sv - randomized and directed checks of target_lut_ram against a table model
module tb_target_lut_ram;
    logic clk = 1'b0;
    logic rst1;
    logic rst2;

    always #5 clk = ~clk;

    target_lut_ram_if #(.ADDR_W(3), .TARGET_W(10)) if1 ();
    target_lut_ram_if #(.ADDR_W(4), .TARGET_W(16)) if2 ();

    target_lut_ram #(.ADDR_W(3), .TARGET_W(10), .MISS_TARGET(1)) dut1 (
        .i_clk  (clk),
        .i_reset(rst1),
        .bus    (if1.slave)
    );

    target_lut_ram #(.ADDR_W(4), .TARGET_W(16), .MISS_TARGET(1)) dut2 (
        .i_clk  (clk),
        .i_reset(rst2),
        .bus    (if2.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Table model: an invalidation marks everything invalid at once and the
    // table then stays unavailable for 8 cycles.
    logic [9:0] m_data [8];
    logic [7:0] m_valid;
    int         m_sweep;
    logic       m_rv;
    logic       m_hit;
    logic [9:0] m_tgt;

    task automatic cycle1(input logic rst, input logic re, input logic [2:0] ra,
                          input logic we, input logic [2:0] wa, input logic [9:0] wd,
                          input logic inv);
        rst1          = rst;
        if1.rd_en     = re;
        if1.rd_addr   = ra;
        if1.wr_en     = we;
        if1.wr_addr   = wa;
        if1.wr_data   = wd;
        if1.inval_all = inv;
        @(posedge clk);
        if (rst) begin
            m_sweep = 8;
            m_valid = '0;
            m_rv    = 1'b0;
            m_hit   = 1'b0;
            m_tgt   = '0;
        end else if (m_sweep > 0) begin
            m_sweep--;
            m_rv = 1'b0;
        end else begin
            m_rv = re;
            if (re) begin
                if (we && !inv && ra == wa) begin
                    m_hit = 1'b1;
                    m_tgt = wd;
                end else begin
                    m_hit = m_valid[ra];
                    m_tgt = m_hit ? m_data[ra] : 10'd1;
                end
            end
            if (inv) begin
                m_sweep = 8;
                m_valid = '0;
            end else if (we) begin
                m_data[wa]  = wd;
                m_valid[wa] = 1'b1;
            end
        end
        #1;
        check_eq("busy",     32'(if1.busy),     32'(m_sweep > 0));
        check_eq("rd_valid", 32'(if1.rd_valid), 32'(m_rv));
        check_eq("rd_hit",   32'(if1.rd_hit),   32'(m_hit));
        check_eq("target",   32'(if1.target),   32'(m_tgt));
    endtask

    task automatic idle1(input int n);
        for (int i = 0; i < n; i++) cycle1(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 10'd0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        rst2 = 1'b1;
        if2.rd_en = 1'b0; if2.rd_addr = '0; if2.wr_en = 1'b0;
        if2.wr_addr = '0; if2.wr_data = '0; if2.inval_all = 1'b0;

        // Power-up sweep, then a miss on address 5.
        cycle1(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 10'd0, 1'b0);
        idle1(8);
        cycle1(1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 10'd0, 1'b0);

        // Write then read, plus a miss.
        cycle1(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 10'd63, 1'b0);
        cycle1(1'b0, 1'b1, 3'd3, 1'b0, 3'd0, 10'd0, 1'b0);
        cycle1(1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 10'd0, 1'b0);

        // Same-cycle bypass.
        cycle1(1'b0, 1'b1, 3'd6, 1'b1, 3'd6, 10'd208, 1'b0);
        cycle1(1'b0, 1'b1, 3'd6, 1'b0, 3'd0, 10'd0, 1'b0);

        // Fill, invalidate with colliding write and read, then everything misses.
        for (int a = 0; a < 8; a++) cycle1(1'b0, 1'b0, 3'd0, 1'b1, 3'(a), 10'(100 + a), 1'b0);
        cycle1(1'b0, 1'b1, 3'd2, 1'b1, 3'd2, 10'd40, 1'b1);
        for (int i = 0; i < 8; i++) cycle1(1'b0, 1'b1, 3'(i), 1'b1, 3'(i), 10'(500 + i), 1'b1);
        for (int a = 0; a < 8; a++) cycle1(1'b0, 1'b1, 3'(a), 1'b0, 3'd0, 10'd0, 1'b0);

        // Reset during the fourth sweep cycle restarts the sweep.
        cycle1(1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 10'd77, 1'b0);
        cycle1(1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 10'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle1(1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 10'd0, 1'b0);
        cycle1(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 10'd0, 1'b0);
        for (int i = 0; i < 9; i++) cycle1(1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 10'd0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle1(($urandom % 64) == 0, ($urandom % 4) != 0, 3'($urandom),
                   ($urandom % 2) == 0, 3'($urandom), 10'($urandom),
                   ($urandom % 24) == 0);
        end

        // Wider instance: sweep length and full-width data at the top index.
        @(posedge clk); #1;
        rst2 = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (if2.busy) busy_cnt++;
            @(posedge clk); #1;
        end
        check_eq("p16_busy_cycles", 32'(busy_cnt), 32'd16);
        if2.wr_en = 1'b1; if2.wr_addr = 4'd15; if2.wr_data = 16'hFFFF;
        @(posedge clk); #1;
        if2.wr_en = 1'b0; if2.rd_en = 1'b1; if2.rd_addr = 4'd15;
        @(posedge clk); #1;
        check_eq("p16_rd_valid", 32'(if2.rd_valid), 32'd1);
        check_eq("p16_rd_hit",   32'(if2.rd_hit),   32'd1);
        check_eq("p16_target",   32'(if2.target),   32'hFFFF);
        if2.rd_addr = 4'd14;
        @(posedge clk); #1;
        check_eq("p16_miss_hit", 32'(if2.rd_hit),   32'd0);
        check_eq("p16_miss_tgt", 32'(if2.target),   32'd1);
        if2.rd_en = 1'b0;
        @(posedge clk); #1;
        check_eq("p16_idle_rv",  32'(if2.rd_valid), 32'd0);
        check_eq("p16_hold_tgt", 32'(if2.target),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
